// File: rtl/lod_pkg.sv
// Shared defaults and result types for the leading-one normaliser family.
package lod_pkg;

  localparam int unsigned LOD_WIDTH = 8;

  function automatic int unsigned pos_w(input int unsigned w);
    return $clog2(w);
  endfunction

  typedef logic [pos_w(LOD_WIDTH)-1:0] lod_pos_t;

  typedef struct packed {
    logic [LOD_WIDTH-1:0] mant;
    lod_pos_t             exp;
    logic                 zero;
  } norm_result_t;

endpackage

// File: rtl/lead_one_enc.sv
// Combinational priority encoder: index of the highest set bit plus an all-zero flag.
module lead_one_enc
  import lod_pkg::*;
#(
  parameter int unsigned WIDTH = LOD_WIDTH,
  parameter int unsigned POS_W = pos_w(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [POS_W-1:0] pos,
  output logic             zero
);

  // Ascending scan: the last set bit seen wins, so the highest one is reported.
  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data[i]) pos = POS_W'(i);
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/lod_norm_pipe.sv
// Two-stage valid/ready pipeline normalising an unsigned word so its leading one sits in the MSB.
module lod_norm_pipe
  import lod_pkg::*;
#(
  parameter int unsigned WIDTH = LOD_WIDTH,
  parameter int unsigned POS_W = pos_w(WIDTH),
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [POS_W-1:0] out_exp,
  output logic             out_zero,
  output logic [CNT_W-1:0] zero_cnt,
  input  logic             clr_cnt
);

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_data;
  logic [POS_W-1:0] s1_pos;
  logic             s1_zero;
  logic [POS_W-1:0] enc_pos;
  logic             enc_zero;
  logic             s1_adv, s2_adv, in_xfer;
  logic [POS_W-1:0] shamt;

  lead_one_enc #(.WIDTH(WIDTH), .POS_W(POS_W)) u_enc (
    .data (in_data),
    .pos  (enc_pos),
    .zero (enc_zero)
  );

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign shamt     = POS_W'(WIDTH - 1) - s1_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_pos   <= '0;
      s1_zero  <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_pos   <= enc_pos;
      s1_zero  <= enc_zero;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // A zero word encodes pos 0, so the shift still yields mant 0 / exp 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_mant <= '0;
      out_exp  <= '0;
      out_zero <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mant <= s1_data << shamt;
        out_exp  <= s1_pos;
        out_zero <= s1_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
    end else if (clr_cnt) begin
      zero_cnt <= '0;
    end else if (in_xfer && enc_zero && (zero_cnt != '1)) begin
      zero_cnt <= zero_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lod_norm_pipe.sv
// Directed bench for lod_norm_pipe: handshake, backpressure, counter saturation, reset, full sweep.
module tb_lod_norm_pipe;
  import lod_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, clr_cnt;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_zero;
  logic [7:0] out_mant;
  logic [2:0] out_exp;
  logic [15:0] zero_cnt;

  logic       v4, c4;
  logic [7:0] d4;
  logic       rdy4, ovld4, oz4;
  logic [7:0] om4;
  logic [2:0] oe4;
  logic [3:0] cnt4;
  logic       or4 = 1'b1;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  lod_norm_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .zero_cnt(zero_cnt), .clr_cnt(clr_cnt)
  );

  lod_norm_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .out_valid(ovld4), .out_ready(or4), .out_mant(om4), .out_exp(oe4),
    .out_zero(oz4), .zero_cnt(cnt4), .clr_cnt(c4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] m, input logic [2:0] e, input logic z);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'({out_mant, out_exp, out_zero}), 32'({m, e, z}));
  endtask

  // Independent reference: shift until the MSB is set, counting the shifts.
  function automatic norm_result_t ref_norm(input logic [7:0] d);
    norm_result_t r;
    int unsigned sh = 0;
    r.mant = d;
    r.zero = (d == 8'h00);
    while (d != 8'h00 && !r.mant[7]) begin
      r.mant = r.mant << 1;
      sh++;
    end
    r.exp = r.zero ? 3'd0 : 3'(7 - sh);
    return r;
  endfunction

  initial begin
    norm_result_t q[$];
    norm_result_t e;
    int unsigned idx;
    int unsigned cyc;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    v4 = 1'b0; d4 = '0; c4 = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fields", 32'({out_mant, out_exp, out_zero}), 32'd0);
    chk("rst_zero_cnt", 32'(zero_cnt), 32'd0);
    #11 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single word, latency 2
    in_valid = 1'b1; in_data = 8'h13;
    tick();
    in_valid = 1'b0;
    chk("lat1_not_valid", 32'(out_valid), 32'd0);
    tick();
    chk_out("lat2", 8'h98, 3'd4, 1'b0);

    // Back-to-back stream
    in_valid = 1'b1; in_data = 8'h80; tick();
    in_data = 8'h01; tick();
    chk_out("stream_80", 8'h80, 3'd7, 1'b0);
    in_data = 8'h00; tick();
    chk_out("stream_01", 8'h80, 3'd0, 1'b0);
    in_data = 8'h40; tick();
    chk_out("stream_00", 8'h00, 3'd0, 1'b1);
    in_valid = 1'b0; tick();
    chk_out("stream_40", 8'h80, 3'd6, 1'b0);
    chk("stream_zero_cnt", 32'(zero_cnt), 32'd1);
    tick();
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Backpressure: two words fill the pipe, third waits
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h21; tick();
    in_data = 8'h05; #1;
    chk("bp_ready_half", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h03; #1;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk_out("bp_hold0", 8'h84, 3'd5, 1'b0);
    tick();
    chk_out("bp_hold1", 8'h84, 3'd5, 1'b0);
    chk("bp_ready_still0", 32'(in_ready), 32'd0);
    out_ready = 1'b1; #1;
    chk("bp_ready_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp_w1", 8'hA0, 3'd2, 1'b0);
    tick();
    chk_out("bp_w2", 8'hC0, 3'd1, 1'b0);
    tick();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Counter saturation on the CNT_W=4 instance
    v4 = 1'b1; d4 = 8'h00;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_cnt14", 32'(cnt4), 32'd14);
    for (int i = 0; i < 3; i++) tick();
    chk("sat_cnt17", 32'(cnt4), 32'd15);
    c4 = 1'b1; tick();
    chk("sat_clr_prio", 32'(cnt4), 32'd0);
    c4 = 1'b0; tick();
    chk("sat_after_clr", 32'(cnt4), 32'd1);
    v4 = 1'b0;

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0;
    chk("mid_full", 32'({out_valid, in_ready}), 32'b10);
    #2 rst_n = 1'b0; #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_fields", 32'({out_mant, out_exp, out_zero}), 32'd0);
    #1 rst_n = 1'b1; #1;
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h0C; tick();
    in_valid = 1'b0; tick();
    chk_out("mid_next", 8'hC0, 3'd3, 1'b0);
    chk("mid_cnt_cleared", 32'(zero_cnt), 32'd0);
    tick();

    // Sweep 0..255 with random out_ready
    idx = 0;
    cyc = 0;
    while ((idx < 256 || q.size() != 0) && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx < 256);
      in_data   = 8'(idx);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sweep_extra_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sweep_res", 32'({out_mant, out_exp, out_zero}), 32'(e));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_norm(8'(idx)));
        idx++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("sweep_complete", 32'(idx + 32'(q.size())), 32'd256);
    chk("sweep_zero_cnt", 32'(zero_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
